// File: rtl/sram_master_pkg.sv
// Shared types and widths for the 16-bit-to-8-bit asynchronous SRAM master.
// The FSM enum is used by both the top level and the per-byte timing block.
package sram_master_pkg;

  localparam int SRAM_AW = 19;
  localparam int SRAM_DW = 8;
  localparam int WORD_W  = 16;
  localparam int ADDR_W  = SRAM_AW - 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } sram_state_e;

  // True while the SRAM chip select is asserted.
  function automatic logic is_active(input sram_state_e s);
    return s inside {SETUP, STROBE, HOLD};
  endfunction

endpackage

// File: rtl/sram_byte_cycle.sv
// One SRAM byte access: SETUP -> STROBE (WAIT_CYCLES cycles) -> HOLD.
// Owns the strobe counter; the caller holds the state register and restarts it.
module sram_byte_cycle
  import sram_master_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  sram_state_e state,
  input  logic        start,
  output sram_state_e state_next,
  output logic        strobe_end
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [3:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == SETUP) begin
      cnt_q <= CNT_LOAD;
    end else if ((state == STROBE) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign strobe_end = (state == STROBE) && (cnt_q == '0);

  // NOTE: the output is assigned a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = IDLE;
    case (state)
      SETUP:   state_next = STROBE;
      STROBE:  state_next = strobe_end ? HOLD : STROBE;
      default: state_next = start ? SETUP : IDLE;
    endcase
  end

endmodule

// File: rtl/sram_master16.sv
// 16-bit fabric master for an 8-bit asynchronous SRAM: each word is two byte cycles.
// Optional macro SRAM_MASTER_BYTE_EN adds a BYTE input for single-byte accesses.
module sram_master16
  import sram_master_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               REQ,
  input  logic               WE,
  input  logic [ADDR_W-1:0]  ADDR,
  input  logic [WORD_W-1:0]  WDATA,
`ifdef SRAM_MASTER_BYTE_EN
  input  logic               BYTE,
`endif
  output logic [WORD_W-1:0]  RDATA,
  output logic               ACK,
  output logic               BUSY,
  inout  wire  [SRAM_DW-1:0] SRAM_D,
  output logic [SRAM_AW-1:0] SRAM_A,
  output logic               SRAM_nCS,
  output logic               SRAM_nOE,
  output logic               SRAM_nWE
);

  sram_state_e       state_q, state_next, bc_next;
  logic              we_q, idx_q, byte_q, strobe_end;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              accept, more, start;
  logic              we_nx, idx_nx, active_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [WORD_W-1:0] wdata_nx;
  logic              drive_q;
  logic [SRAM_DW-1:0] dout_q;

  assign accept = (state_q == IDLE) && REQ;
  assign more   = (state_q == HOLD) && !idx_q && !byte_q;
  assign start  = accept || more;

  sram_byte_cycle #(.WAIT_CYCLES(WAIT_CYCLES)) u_byte_cycle (
    .clk        (clk),
    .reset      (reset),
    .state      (state_q),
    .start      (start),
    .state_next (bc_next),
    .strobe_end (strobe_end)
  );

  always_comb begin
    state_next = bc_next;
    case (state_q)
      HOLD:    state_next = more ? SETUP : DONE;
      DONE:    state_next = IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  // Values in force next cycle; the SRAM pins are registered from these so
  // they change cleanly on the edge without a combinational path to the bus.
  assign we_nx     = accept ? WE    : we_q;
  assign addr_nx   = accept ? ADDR  : addr_q;
  assign wdata_nx  = accept ? WDATA : wdata_q;
  assign idx_nx    = accept ? 1'b0  : (more ? 1'b1 : idx_q);
  assign active_nx = is_active(state_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= WE;
        addr_q  <= ADDR;
        wdata_q <= WDATA;
      end
      idx_q <= idx_nx;
    end
  end

`ifdef SRAM_MASTER_BYTE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       byte_q <= 1'b0;
    else if (accept) byte_q <= BYTE;
  end
`else
  assign byte_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      SRAM_nCS <= 1'b1;
      SRAM_nOE <= 1'b1;
      SRAM_nWE <= 1'b1;
      SRAM_A   <= '0;
      drive_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      SRAM_nCS <= !active_nx;
      SRAM_nOE <= !((state_next == STROBE) && !we_nx);
      SRAM_nWE <= !((state_next == STROBE) && we_nx);
      drive_q  <= active_nx && we_nx;
      if (state_next == SETUP) begin
        SRAM_A <= {addr_nx, idx_nx};
        dout_q <= idx_nx ? wdata_nx[15:8] : wdata_nx[7:0];
      end
    end
  end

  // Read data is captured on the edge that closes the last strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RDATA <= '0;
    end else if (strobe_end && !we_q) begin
      if (idx_q) begin
        RDATA[15:8] <= SRAM_D;
      end else begin
        RDATA[7:0] <= SRAM_D;
        if (byte_q) RDATA[15:8] <= '0;
      end
    end
  end

  assign SRAM_D = drive_q ? dout_q : {SRAM_DW{1'bz}};
  assign ACK    = (state_q == DONE);
  assign BUSY   = (state_q != IDLE);

endmodule
